// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_IDX  = 0;

    // Ceiling log2, used to derive the register address width.
    function automatic int clog2(input int n);
        int r;
        r = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 32'sd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, set wins on a collision.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = clog2(NREGS),
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_rd,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    busy_out,
    output logic              any_busy
);

    localparam bit            ZR        = (ZERO_REG != 32'sd0);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             iss_ok_s;

    // Next busy vector: writeback clears first, then the issue sets so a new producer wins.
    always_comb begin
        busy_d   = busy_q;
        iss_ok_s = iss_en & ~(ZR & (iss_rd == ZERO_ADDR));
        for (int p = 0; p < NWR; p++) begin
            busy_d[wr_addr[p*AW +: AW]] = wr_en[p] ? 1'b0 : busy_d[wr_addr[p*AW +: AW]];
        end
        if (iss_ok_s) begin
            busy_d[iss_rd] = 1'b1;
        end else begin
            busy_d[iss_rd] = busy_d[iss_rd];
        end
    end

    // Busy state register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= {NREGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    // Stored busy flag per read port; the zero register never reports busy.
    always_comb begin
        busy_out = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            busy_out[i] = busy_q[rd_addr[i*AW +: AW]] &
                          ~(ZR & (rd_addr[i*AW +: AW] == ZERO_ADDR));
        end
    end

    assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write bypass and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = clog2(NREGS),
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    output logic                any_busy
);

    localparam bit            ZR        = (ZERO_REG != 32'sd0);
    localparam bit            BP        = (BYPASS != 32'sd0);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];
    logic [NRD-1:0]  sb_busy_s;
    logic [NRD-1:0]  fwd_hit_s;

    // Write merge: ports applied in ascending order so the highest index wins.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && !(ZR && (wr_addr[p*AW +: AW] == ZERO_ADDR))) begin
                mem_d[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
            end else begin
                mem_d[wr_addr[p*AW +: AW]] = mem_d[wr_addr[p*AW +: AW]];
            end
        end
    end

    // Register array, cleared asynchronously so nothing reads X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= {XLEN{1'b0}};
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    // Combinational read with forwarding; forwarding is held off during reset so reads show 0.
    always_comb begin
        rd_data   = {(NRD*XLEN){1'b0}};
        fwd_hit_s = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            rd_data[i*XLEN +: XLEN] = mem_q[rd_addr[i*AW +: AW]];
            for (int p = 0; p < NWR; p++) begin
                if (BP && rst_n && wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr[i*AW +: AW])) begin
                    rd_data[i*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
                    fwd_hit_s[i]            = 1'b1;
                end else begin
                    rd_data[i*XLEN +: XLEN] = rd_data[i*XLEN +: XLEN];
                end
            end
            if (ZR && (rd_addr[i*AW +: AW] == ZERO_ADDR)) begin
                rd_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
            end else begin
                rd_data[i*XLEN +: XLEN] = rd_data[i*XLEN +: XLEN];
            end
        end
    end

    // A forwarded value is ready, so that read no longer needs to stall.
    assign rd_busy = sb_busy_s & ~fwd_hit_s;

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .busy_out (sb_busy_s),
        .any_busy (any_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: instance A (zero reg + bypass) and B (no zero reg, no bypass), shared stimulus.
module tb_regfile_mp;

    logic         clk;
    logic         rst_n;
    logic [19:0]  rd_addr;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         iss_en;
    logic [4:0]   iss_rd;
    logic [127:0] rd_data_a, rd_data_b;
    logic [3:0]   rd_busy_a, rd_busy_b;
    logic         any_busy_a, any_busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, index 0 = instance A, 1 = instance B
    logic [31:0] m_regs [2][32];
    logic        m_busy [2][32];
    bit          zr_c   [2] = '{1'b1, 1'b0};
    bit          bp_c   [2] = '{1'b1, 1'b0};

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(4), .NWR(2), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
        .any_busy(any_busy_a)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(4), .NWR(2), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
        .any_busy(any_busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        wr_en   = 2'b00;
        wr_addr = 10'd0;
        wr_data = 64'd0;
        iss_en  = 1'b0;
        iss_rd  = 5'd0;
        rd_addr = 20'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 32; r++) begin
                m_regs[c][r] = 32'd0;
                m_busy[c][r] = 1'b0;
            end
    endtask

    // Apply the architectural effect of one clock edge to the model
    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 2; p++) begin
                int a;
                a = wr_addr[p*5 +: 5];
                if (wr_en[p]) begin
                    if (!(zr_c[c] && a == 0)) m_regs[c][a] = wr_data[p*32 +: 32];
                    m_busy[c][a] = 1'b0;
                end
            end
            if (iss_en && !(zr_c[c] && iss_rd == 5'd0)) m_busy[c][iss_rd] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        rd_addr = 20'h8_41_83;
        #3;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rd_data_a[i*32 +: 32] !== 32'd0 || rd_data_b[i*32 +: 32] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_rd_data port%0d: got a=%h b=%h expected 0", i,
                         rd_data_a[i*32 +: 32], rd_data_b[i*32 +: 32]);
            end
        end
        n_tests++;
        if (rd_busy_a !== 4'd0 || rd_busy_b !== 4'd0 || any_busy_a !== 1'b0 || any_busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b %b %b %b expected all 0", rd_busy_a, rd_busy_b, any_busy_a, any_busy_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_write();
        clear_inputs();
        wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'hDEADBEEF;
        iss_en = 1'b1; iss_rd = 5'd6;
        tick();
        clear_inputs();
        rd_addr[4:0] = 5'd5; rd_addr[9:5] = 5'd6;
        @(negedge clk);
        n_tests++;
        if (rd_data_a[31:0] !== 32'hDEADBEEF || any_busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_x5: got %h busy=%b expected deadbeef busy=1", rd_data_a[31:0], any_busy_a);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (rd_data_a[31:0] !== 32'd0 || rd_data_b[31:0] !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset_x5: got a=%h b=%h expected 0", rd_data_a[31:0], rd_data_b[31:0]);
        end
        n_tests++;
        if (any_busy_a !== 1'b0 || any_busy_b !== 1'b0 || rd_busy_a[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_busy: got %b %b %b expected 0", any_busy_a, any_busy_b, rd_busy_a[1]);
        end
        rst_n = 1'b1;
        wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'h1234;
        tick();
        clear_inputs();
        rd_addr[4:0] = 5'd5;
        @(negedge clk);
        n_tests++;
        if (rd_data_a[31:0] !== 32'h1234 || rd_data_b[31:0] !== 32'h1234) begin
            n_fail++;
            $display("FAIL write_after_reset: got a=%h b=%h expected 1234", rd_data_a[31:0], rd_data_b[31:0]);
        end
    endtask

    task automatic test_zero_reg();
        tick();
        clear_inputs();
        wr_en = 2'b01; wr_addr[4:0] = 5'd0; wr_data[31:0] = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_rd = 5'd0;
        tick();
        clear_inputs();
        @(negedge clk);
        n_tests++;
        if (rd_data_a[31:0] !== 32'd0 || rd_busy_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_a: got %h busy=%b expected 0 busy=0", rd_data_a[31:0], rd_busy_a[0]);
        end
        n_tests++;
        if (rd_data_b[31:0] !== 32'hFFFFFFFF || rd_busy_b[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_reg_b: got %h busy=%b expected ffffffff busy=1", rd_data_b[31:0], rd_busy_b[0]);
        end
        tick();
        wr_en = 2'b01; wr_addr[4:0] = 5'd0; wr_data[31:0] = 32'd0;
        tick();
        clear_inputs();
    endtask

    task automatic test_bypass();
        wr_en = 2'b01; wr_addr[4:0] = 5'd7; wr_data[31:0] = 32'h11111111;
        tick();
        wr_data[31:0] = 32'hA5A5A5A5;
        rd_addr[9:5] = 5'd7;
        #1;
        n_tests++;
        if (rd_data_a[63:32] !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL bypass_a: got %h expected a5a5a5a5", rd_data_a[63:32]);
        end
        n_tests++;
        if (rd_data_b[63:32] !== 32'h11111111) begin
            n_fail++;
            $display("FAIL no_bypass_b: got %h expected 11111111", rd_data_b[63:32]);
        end
        tick();
        clear_inputs();
        rd_addr[9:5] = 5'd7;
        #1;
        n_tests++;
        if (rd_data_b[63:32] !== 32'hA5A5A5A5 || rd_data_a[63:32] !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: got a=%h b=%h expected a5a5a5a5", rd_data_a[63:32], rd_data_b[63:32]);
        end
    endtask

    task automatic test_write_conflict();
        clear_inputs();
        wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h2, 32'h1};
        rd_addr[14:10] = 5'd9;
        #1;
        n_tests++;
        if (rd_data_a[95:64] !== 32'h2) begin
            n_fail++;
            $display("FAIL conflict_bypass: got %h expected 2", rd_data_a[95:64]);
        end
        tick();
        clear_inputs();
        rd_addr[14:10] = 5'd9;
        #1;
        n_tests++;
        if (rd_data_a[95:64] !== 32'h2 || rd_data_b[95:64] !== 32'h2) begin
            n_fail++;
            $display("FAIL conflict_array: got a=%h b=%h expected 2", rd_data_a[95:64], rd_data_b[95:64]);
        end
    endtask

    task automatic test_scoreboard();
        clear_inputs();
        iss_en = 1'b1; iss_rd = 5'd3;
        tick();
        clear_inputs();
        rd_addr[4:0] = 5'd3;
        #1;
        n_tests++;
        if (rd_busy_a[0] !== 1'b1 || rd_busy_b[0] !== 1'b1 || any_busy_a !== 1'b1 || any_busy_b !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_busy: got %b %b %b %b expected 1", rd_busy_a[0], rd_busy_b[0], any_busy_a, any_busy_b);
        end
        wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'h33;
        #1;
        n_tests++;
        if (rd_busy_a[0] !== 1'b0 || rd_busy_b[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clearing_cycle_busy: got a=%b b=%b expected a=0 b=1", rd_busy_a[0], rd_busy_b[0]);
        end
        tick();
        clear_inputs();
        rd_addr[4:0] = 5'd3;
        #1;
        n_tests++;
        if (rd_busy_a[0] !== 1'b0 || rd_busy_b[0] !== 1'b0 || any_busy_a !== 1'b0 || any_busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL write_clears_busy: got %b %b %b %b expected 0", rd_busy_a[0], rd_busy_b[0], any_busy_a, any_busy_b);
        end
        iss_en = 1'b1; iss_rd = 5'd3;
        wr_en = 2'b10; wr_addr[9:5] = 5'd3; wr_data[63:32] = 32'h44;
        tick();
        clear_inputs();
        rd_addr[4:0] = 5'd3;
        #1;
        n_tests++;
        if (rd_busy_a[0] !== 1'b1 || rd_busy_b[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL set_wins: got a=%b b=%b expected 1", rd_busy_a[0], rd_busy_b[0]);
        end
        wr_en = 2'b01; wr_addr[4:0] = 5'd3;
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [127:0] act_d;
        logic [3:0]   act_b;
        logic         act_any;
        logic [31:0]  exp_d;
        logic         exp_b, exp_any, hit;
        int           a;
        rst_n = 1'b0;
        model_clear();
        clear_inputs();
        tick();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_clear();
            end else begin
                rst_n = 1'b1;
            end
            wr_en  = 2'($urandom_range(0, 3));
            iss_en = ($urandom_range(0, 4) < 2);
            iss_rd = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            for (int p = 0; p < 2; p++) begin
                wr_addr[p*5 +: 5]  = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
                wr_data[p*32 +: 32] = $urandom;
            end
            for (int i = 0; i < 4; i++)
                rd_addr[i*5 +: 5] = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                act_d   = (c == 0) ? rd_data_a : rd_data_b;
                act_b   = (c == 0) ? rd_busy_a : rd_busy_b;
                act_any = (c == 0) ? any_busy_a : any_busy_b;
                for (int i = 0; i < 4; i++) begin
                    a     = rd_addr[i*5 +: 5];
                    exp_d = m_regs[c][a];
                    hit   = 1'b0;
                    if (bp_c[c] && rst_n)
                        for (int p = 0; p < 2; p++)
                            if (wr_en[p] && wr_addr[p*5 +: 5] == a) begin
                                exp_d = wr_data[p*32 +: 32];
                                hit   = 1'b1;
                            end
                    if (zr_c[c] && a == 0) exp_d = 32'd0;
                    exp_b = m_busy[c][a] && !hit && !(zr_c[c] && a == 0);
                    n_tests++;
                    if (act_d[i*32 +: 32] !== exp_d) begin
                        n_fail++;
                        $display("FAIL rand_rd_data cfg%0d port%0d cycle%0d: got %h expected %h",
                                 c, i, cyc, act_d[i*32 +: 32], exp_d);
                    end
                    n_tests++;
                    if (act_b[i] !== exp_b) begin
                        n_fail++;
                        $display("FAIL rand_rd_busy cfg%0d port%0d cycle%0d: got %b expected %b",
                                 c, i, cyc, act_b[i], exp_b);
                    end
                end
                exp_any = 1'b0;
                for (int r = 0; r < 32; r++) exp_any = exp_any | m_busy[c][r];
                n_tests++;
                if (act_any !== exp_any) begin
                    n_fail++;
                    $display("FAIL rand_any_busy cfg%0d cycle%0d: got %b expected %b", c, cyc, act_any, exp_any);
                end
            end
            @(posedge clk);
            if (rst_n) model_edge();
            #1;
        end
        rst_n = 1'b1;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_reset_write();
        test_zero_reg();
        test_bypass();
        test_write_conflict();
        test_scoreboard();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined core; successor to the single-write/dual-read integer regfile.
- Adds configurable width, depth, read-port and write-port counts, an asynchronous reset that clears state, optional same-cycle write-to-read bypass, and a per-register busy scoreboard.
- Sits between decode (read ports, issue) and writeback (write ports).
- Decode uses the busy flags to stall on RAW hazards.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; must be a power of 2, at least 2.
- AW, $clog2(NREGS), register address width; derived, do not override.
- NRD, 2, number of read ports, 1..4.
- NWR, 1, number of write ports, 1..2.
- ZERO_REG, 1, register 0 reads as zero, ignores writes and is never busy.
- BYPASS, 1, a read of an address being written this cycle returns the write data.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rd_addr  input  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd_data  output  NRD*XLEN  packed read data.
- rd_busy  output  NRD  busy flag of each read address.
- wr_en  input  NWR  per-port write enable.
- wr_addr  input  NWR*AW  packed write addresses.
- wr_data  input  NWR*XLEN  packed write data.
- iss_en  input  1  an instruction issues with destination iss_rd.
- iss_rd  input  AW  destination register being issued.
- any_busy  output  1  OR of all busy bits (used for drain/flush).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers and all busy bits become 0 immediately.
  - rd_data shows 0 for every address; rd_busy = 0; any_busy = 0.
  - Deassertion takes effect at the next rising clk edge.
- Reads are combinational, 0 cycles latency. rd_data[i] is:
  - 0 if ZERO_REG=1 and rd_addr[i]==0;
  - otherwise, with BYPASS=1, wr_data of the highest-index write port with wr_en=1 and a matching address;
  - otherwise the stored value.
  - With BYPASS=0 the stored value is returned; a write becomes visible the cycle after the edge.
- Writes:
  - On the rising edge, for each port p with wr_en[p]=1, the register at wr_addr[p] takes wr_data[p].
  - With ZERO_REG=1, writes to address 0 are dropped.
  - Two ports writing the same address in the same cycle: the higher-index port wins, both in the array and in the bypass.
- Scoreboard, one busy bit per register:
  - Set on the edge: iss_en=1 sets busy[iss_rd], unless iss_rd==0 and ZERO_REG=1.
  - Clear on the edge: any write-port hit on address a clears busy[a].
  - Same address set and cleared in the same cycle: set wins, because a new producer is in flight.
  - Issue to an already-busy register: the bit stays 1.
  - A write to a non-busy register is legal and leaves the bit at 0.
- rd_busy[i]:
  - BYPASS=1: busy[rd_addr[i]] & ~(a write port hits rd_addr[i] this cycle), since the value is forwarded.
  - BYPASS=0: busy[rd_addr[i]] unmodified.
  - Always 0 for address 0 when ZERO_REG=1.
- any_busy is a combinational OR of the stored busy bits.
- Addresses at or above NREGS cannot occur; AW is exact.
- No X propagation: all storage is reset.

Decomposition:
- Shared package regfile_pkg holds:
  - XLEN_DEF=32 and NREGS_DEF=32;
  - a function clog2 for AW;
  - a localparam for zero-register index 0.
- One sub-module, regfile_scoreboard:
  - contains the NREGS busy bits with their set/clear priority and the any_busy reduction;
  - ports: clk, rst_n, iss_en, iss_rd, wr_en, wr_addr, rd_addr, busy_out.
- Data array, bypass mux and write-priority logic stay in regfile_mp.

Test Plan (default parameters unless stated):
- Reset and write:
  - Assert rst_n=0 mid-run after writing x5=32'hDEADBEEF → rd_data for x5 reads 0 immediately, before any clk edge; any_busy=0.
  - Then write x5=32'h1234 and read on the next cycle → 32'h1234.
- Zero register:
  - Write x0=32'hFFFFFFFF with iss_en, iss_rd=0 → rd_data(x0)=0 and rd_busy=0.
  - With ZERO_REG=0, the same sequence reads back 32'hFFFFFFFF.
- Bypass:
  - BYPASS=1: write x7=32'hA5A5A5A5 while rd_addr port 1 = 7 in the same cycle → rd_data port1 = 32'hA5A5A5A5 combinationally.
  - BYPASS=0: the same stimulus shows the old value, then 32'hA5A5A5A5 on the next cycle.
- Write conflict:
  - NWR=2: both ports write x9, port0=32'h1 and port1=32'h2 → x9 reads 32'h2; the bypass also shows 32'h2.
- Scoreboard:
  - Issue x3 → rd_busy(x3)=1 and any_busy=1.
  - Write x3 → cleared on the next edge.
  - Issue x3 and write x3 in the same cycle → stays 1.
  - With BYPASS=1, rd_busy(x3)=0 during the clearing write cycle.
- Random regression:
  - NRD=4, NWR=2, 10k cycles of random issue/write/read against a reference model.
  - Compare rd_data and rd_busy every cycle, with reset pulses injected at random points.
